// File: rtl/layer_output_streamer_if.sv
// Bundles the per-neuron capture bus and the serial valid/ready stream of
// layer_output_streamer. The streamer uses the slave view; the producer and consumer use master.
interface layer_output_streamer_if #(
  parameter int unsigned numNeurons = 32,
  parameter int unsigned dataWidth  = 8
);
  logic [numNeurons*dataWidth-1:0] neuronOutBus;
  logic [numNeurons-1:0]           neuronOutValid;
  logic                            streamReady;
  logic [dataWidth-1:0]            streamData;
  logic                            streamValid;
  logic                            streamFirst;
  logic                            streamLast;

  modport master (
    output neuronOutBus, neuronOutValid, streamReady,
    input  streamData, streamValid, streamFirst, streamLast
  );

  modport slave (
    input  neuronOutBus, neuronOutValid, streamReady,
    output streamData, streamValid, streamFirst, streamLast
  );
endinterface

// File: rtl/layer_output_streamer.sv
// Collects one layer's neuron activations as each neuron first reports valid,
// then replays them in neuron order as a valid/ready serial stream.
module layer_output_streamer #(
  parameter int unsigned numNeurons = 32,
  parameter int unsigned dataWidth  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   layerStart,
  layer_output_streamer_if.slave streamIf,
  output logic                   busy,
  output logic                   layerDone
);
  localparam int unsigned indexWidth = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [indexWidth-1:0] lastIndex = indexWidth'(numNeurons - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, STREAM, DONE} state_t;

  state_t                  state;
  state_t                  stateNext;
  logic [numNeurons-1:0]   flags;
  logic [numNeurons-1:0]   captureMask;
  logic [numNeurons-1:0]   flagsNext;
  logic [dataWidth-1:0]    buffer [numNeurons];
  logic [indexWidth-1:0]   ptr;
  logic                    atLast;
  logic                    transfer;

  always_comb begin
    captureMask = '0;
    if (state == COLLECT) captureMask = streamIf.neuronOutValid & ~flags;
    flagsNext = flags | captureMask;
    atLast    = (ptr == lastIndex);
    transfer  = (state == STREAM) && streamIf.streamReady;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Leaving COLLECT is decided on the flag values being registered this edge,
  // so the first element is presented the cycle after the last capture.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (layerStart) stateNext = COLLECT;
      COLLECT: if (&flagsNext) stateNext = STREAM;
      STREAM:  if (transfer && atLast) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= '0;
      ptr   <= '0;
      for (int unsigned i = 0; i < numNeurons; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE: if (layerStart) flags <= '0;
        COLLECT: begin
          flags <= flagsNext;
          ptr   <= '0;
          for (int unsigned i = 0; i < numNeurons; i++) begin
            if (captureMask[i]) buffer[i] <= streamIf.neuronOutBus[i*dataWidth +: dataWidth];
          end
        end
        STREAM: if (transfer) ptr <= atLast ? '0 : ptr + indexWidth'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    streamIf.streamValid = (state == STREAM);
    streamIf.streamData  = '0;
    streamIf.streamFirst = 1'b0;
    streamIf.streamLast  = 1'b0;
    if (state == STREAM) begin
      streamIf.streamData  = buffer[ptr];
      streamIf.streamFirst = (ptr == '0);
      streamIf.streamLast  = atLast;
    end
    busy      = (state != IDLE);
    layerDone = (state == DONE);
  end
endmodule

// File: tb/tb_layer_output_streamer.sv
// Randomized bench for layer_output_streamer: expected stream contents and timing
// come from each neuron's first-valid cycle in the generated capture schedule.
module tb_layer_output_streamer;
  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic layerStart = 1'b0;
  logic busy;
  logic layerDone;
  int   checks = 0;
  int   failures = 0;

  layer_output_streamer_if #(.numNeurons(N), .dataWidth(W)) sif ();

  layer_output_streamer #(.numNeurons(N), .dataWidth(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .layerStart(layerStart),
    .streamIf  (sif.slave),
    .busy      (busy),
    .layerDone (layerDone)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkValue({tag, "_valid"}, 32'(sif.streamValid), 0);
    checkValue({tag, "_data"},  32'(sif.streamData),  0);
    checkValue({tag, "_first"}, 32'(sif.streamFirst), 0);
    checkValue({tag, "_last"},  32'(sif.streamLast),  0);
    checkValue({tag, "_busy"},  32'(busy),            0);
    checkValue({tag, "_done"},  32'(layerDone),       0);
  endtask

  // pattern: 0 random, 1 all neurons at once with 01..04, 2 staggered hold-high
  // readyMode: 0 always ready, 1 random ready, 2 three-cycle stall on element 1
  // Each task starts and ends 1 time unit after a rising edge.
  task automatic runLayer(input int pattern, input int readyMode, input bit extraStarts, input int abortAt);
    logic [W-1:0]   expVal [N];
    int             firstCyc [N];
    int             holdLen [N];
    int             maxFirst;
    int             idx;
    int             budget;
    int             stallLeft;
    logic [N*W-1:0] busVal;
    logic [W-1:0]   slice;
    logic [N-1:0]   validVal;

    maxFirst = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (pattern == 1) begin
        firstCyc[i] = 1; holdLen[i] = 1;
      end else if (pattern == 2) begin
        firstCyc[i] = (i == 2) ? 1 : 4;
        holdLen[i]  = (i == 2) ? 6 : 1;
      end else begin
        firstCyc[i] = int'($urandom_range(0, 6));
        holdLen[i]  = int'($urandom_range(1, 4));
      end
      if (firstCyc[i] > maxFirst) maxFirst = firstCyc[i];
      expVal[i] = '0;
    end

    // IDLE cycle: start pulse plus random valids that must be ignored
    layerStart = 1'b1;
    sif.neuronOutValid = N'($urandom);
    sif.neuronOutBus   = (N*W)'({$urandom, $urandom});
    sif.streamReady    = 1'b1;
    @(negedge clk);
    checkValue("idleBusy", 32'(busy), 0);
    @(posedge clk); #1;
    layerStart = 1'b0;

    for (int k = 0; k <= maxFirst; k++) begin
      busVal = '0;
      validVal = '0;
      for (int i = 0; i < int'(N); i++) begin
        validVal[i] = (k >= firstCyc[i]) && (k < firstCyc[i] + holdLen[i]);
        if (pattern == 1)                slice = W'(i + 1);
        else if (pattern == 2 && i == 2) slice = (k < 3) ? 8'h7F : 8'h11;
        else                             slice = W'($urandom);
        busVal[i*W +: W] = slice;
        if (k == firstCyc[i]) expVal[i] = slice;
      end
      sif.neuronOutValid = validVal;
      sif.neuronOutBus   = busVal;
      layerStart = extraStarts && (k == maxFirst);
      @(negedge clk);
      checkValue("collectBusy", 32'(busy), 1);
      checkValue("collectValid", 32'(sif.streamValid), 0);
      @(posedge clk); #1;
    end

    idx = 0;
    budget = 0;
    stallLeft = 3;
    while (idx < int'(N) && budget < 200) begin
      sif.neuronOutValid = N'($urandom);
      sif.neuronOutBus   = (N*W)'({$urandom, $urandom});
      layerStart = extraStarts ? 1'($urandom_range(0, 1)) : 1'b0;
      if (readyMode == 1)                       sif.streamReady = 1'($urandom_range(0, 1));
      else if (readyMode == 2 && idx == 1 && stallLeft > 0) begin
        sif.streamReady = 1'b0; stallLeft--;
      end else                                  sif.streamReady = 1'b1;
      @(negedge clk);
      checkValue("streamValid", 32'(sif.streamValid), 1);
      checkValue("streamData",  32'(sif.streamData),  32'(expVal[idx]));
      checkValue("streamFirst", 32'(sif.streamFirst), 32'(idx == 0));
      checkValue("streamLast",  32'(sif.streamLast),  32'(idx == int'(N) - 1));
      checkValue("streamDone",  32'(layerDone), 0);
      if (idx == abortAt) begin
        #2 reset_n = 1'b0;
        #1 checkIdleOutputs("abort");
        @(posedge clk); #1;
        reset_n = 1'b1;
        layerStart = 1'b0;
        sif.neuronOutValid = '0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checkIdleOutputs("postAbort");
          @(posedge clk); #1;
        end
        return;
      end
      if (sif.streamReady) idx++;
      budget++;
      @(posedge clk); #1;
    end
    if (budget >= 200) checkValue("streamTimeout", 32'(idx), N);

    layerStart = extraStarts;
    sif.streamReady = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkValue("doneCycle", 32'(layerDone), 1);
    checkValue("doneBusy", 32'(busy), 1);
    checkValue("doneValid", 32'(sif.streamValid), 0);
    @(posedge clk); #1;
    layerStart = 1'b0;
    @(negedge clk);
    checkValue("afterDone", 32'(layerDone), 0);
    checkValue("afterBusy", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic neverComplete();
    logic [N-1:0] mask;
    mask = '1;
    mask[$urandom_range(0, N-1)] = 1'b0;
    layerStart = 1'b1;
    @(posedge clk); #1;
    layerStart = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sif.neuronOutValid = mask;
      sif.neuronOutBus   = (N*W)'({$urandom, $urandom});
      sif.streamReady    = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkValue("stuckBusy", 32'(busy), 1);
      checkValue("stuckValid", 32'(sif.streamValid), 0);
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1 checkIdleOutputs("stuckReset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    sif.neuronOutValid = '0;
  endtask

  initial begin
    sif.neuronOutValid = '0;
    sif.neuronOutBus   = '0;
    sif.streamReady    = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkIdleOutputs("reset");
    reset_n = 1'b1;

    runLayer(1, 0, 1'b0, -1);
    runLayer(2, 0, 1'b0, -1);
    runLayer(0, 2, 1'b0, -1);
    runLayer(0, 1, 1'b1, -1);
    for (int r = 0; r < 6; r++) runLayer(0, 1, 1'b0, -1);
    runLayer(0, 0, 1'b0, 2);
    runLayer(0, 1, 1'b0, -1);
    neverComplete();
    runLayer(0, 0, 1'b0, -1);
    runLayer(1, 1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
